// File: rtl/lfm_phase_gen_if.sv
// Handshake and sample bundle between the chirp phase generator and its
// requester/consumer; modport slave is the generator side.
interface lfm_phase_gen_if #(
    parameter int OUT_W = 12
);
    logic             START;
    logic             READY;
    logic [OUT_W-1:0] PHASE;
    logic             VALID;
    logic             SIGN_START_CALC;
    logic             SIGN_STOP_CALC;
    logic             BUSY;

    modport slave (
        input  START,
        input  READY,
        output PHASE,
        output VALID,
        output SIGN_START_CALC,
        output SIGN_STOP_CALC,
        output BUSY
    );

    modport master (
        output START,
        output READY,
        input  PHASE,
        input  VALID,
        input  SIGN_START_CALC,
        input  SIGN_STOP_CALC,
        input  BUSY
    );
endinterface

// File: rtl/lfm_phase_gen.sv
// LFM chirp phase generator: quadratic phase from a ramped frequency word.
// Define LFM_DOWN_CHIRP_EN for a descending chirp (frequency word decrements).
module lfm_phase_gen #(
    parameter int                 PHASE_W   = 32,
    parameter int                 OUT_W     = 12,
    parameter logic [PHASE_W-1:0] FREQ_INIT = 32'h0100_0000,
    parameter logic [PHASE_W-1:0] FREQ_STEP = 32'h0000_1000,
    parameter logic [15:0]        PULSE_LEN = 16'd1000
) (
    input  logic           CLK,
    input  logic           RESET,
    lfm_phase_gen_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] w_acc_nxt;
    logic [PHASE_W-1:0] r_freq;
    logic [PHASE_W-1:0] w_freq_nxt;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_nxt;
    logic [OUT_W-1:0]   r_phase;
    logic [OUT_W-1:0]   w_phase_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_sstart;
    logic               w_sstart_nxt;
    logic               r_sstop;
    logic               w_sstop_nxt;

    logic               w_req;
    logic               w_last;
    logic [PHASE_W-1:0] w_freq_upd;
    logic [PHASE_W-1:0] w_freq_first;

`ifdef LFM_DOWN_CHIRP_EN
    assign w_freq_upd   = r_freq - FREQ_STEP;
    assign w_freq_first = FREQ_INIT - FREQ_STEP;
`else
    assign w_freq_upd   = r_freq + FREQ_STEP;
    assign w_freq_first = FREQ_INIT + FREQ_STEP;
`endif

    assign w_req  = bus.START && bus.READY;
    assign w_last = (r_state == S_RUN) && (r_cnt == PULSE_LEN);

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_freq_nxt   = r_freq;
        w_cnt_nxt    = r_cnt;
        w_phase_nxt  = '0;
        w_valid_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_sstart_nxt = 1'b0;
        w_sstop_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt  = S_RUN;
                    w_acc_nxt    = FREQ_INIT;
                    w_freq_nxt   = w_freq_first;
                    w_cnt_nxt    = 16'd1;
                    w_valid_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_sstart_nxt = 1'b1;
                    w_sstop_nxt  = (PULSE_LEN == 16'd1);
                end
            end
            S_RUN: begin
                if (w_last) begin
                    // Back-to-back pulse is allowed on the closing edge
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_freq_nxt  = FREQ_INIT;
                    w_cnt_nxt   = '0;
                    if (w_req) begin
                        w_state_nxt  = S_RUN;
                        w_acc_nxt    = FREQ_INIT;
                        w_freq_nxt   = w_freq_first;
                        w_cnt_nxt    = 16'd1;
                        w_valid_nxt  = 1'b1;
                        w_busy_nxt   = 1'b1;
                        w_sstart_nxt = 1'b1;
                        w_sstop_nxt  = (PULSE_LEN == 16'd1);
                    end
                end else begin
                    w_phase_nxt = r_acc[PHASE_W-1 -: OUT_W];
                    w_acc_nxt   = r_acc + r_freq;
                    w_freq_nxt  = w_freq_upd;
                    w_cnt_nxt   = r_cnt + 16'd1;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_sstop_nxt = (r_cnt == PULSE_LEN - 16'd1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_freq   <= FREQ_INIT;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_sstart <= 1'b0;
            r_sstop  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_freq   <= w_freq_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_sstart <= w_sstart_nxt;
            r_sstop  <= w_sstop_nxt;
        end
    end

    assign bus.PHASE           = r_phase;
    assign bus.VALID           = r_valid;
    assign bus.BUSY            = r_busy;
    assign bus.SIGN_START_CALC = r_sstart;
    assign bus.SIGN_STOP_CALC  = r_sstop;

endmodule

// File: doc/lfm_phase_gen.md
# lfm_phase_gen

Linear-FM chirp phase generator for the LFM DDS chain. On a start request it runs a phase accumulator whose frequency word is itself ramped every sample, producing a quadratic phase sequence. The truncated phase word feeds the sine lookup stage. The block also issues the one-cycle start and stop markers that the downstream output register uses to frame the pulse.

## Interface
Parameters:
- PHASE_W, 32: accumulator and frequency-word width.
- OUT_W, 12: width of the emitted phase word (top OUT_W bits of the accumulator); OUT_W ≤ PHASE_W.
- FREQ_INIT, 32'h0100_0000: frequency word for sample 0 (chirp start frequency).
- FREQ_STEP, 32'h0000_1000: frequency-word increment per sample (chirp rate).
- PULSE_LEN, 16'd1000: samples per pulse, ≥ 1.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  pulse request, level-sampled each edge.
- READY  in  1  downstream output register idle (high = may accept a new pulse).
- PHASE  out  OUT_W  phase word to sine LUT.
- VALID  out  1  PHASE holds a pulse sample this cycle.
- SIGN_START_CALC  out  1  one-cycle marker on sample 0.
- SIGN_STOP_CALC  out  1  one-cycle marker on sample PULSE_LEN-1.
- BUSY  out  1  pulse in progress.

## Operation
- States: IDLE, RUN. All outputs registered.
- IDLE: accumulator = 0, freq = FREQ_INIT, sample counter = 0; VALID, BUSY, SIGN_START_CALC, SIGN_STOP_CALC = 0; PHASE = 0.
- IDLE -> RUN when START = 1 and READY = 1 at an edge. START with READY = 0 is held off (not latched) until READY rises while START is still high.
- RUN, per edge: emit PHASE = acc[PHASE_W-1 -: OUT_W], then update acc ← acc + freq and freq ← freq + FREQ_STEP. Both updates wrap modulo 2^PHASE_W, and overflow is discarded. The counter increments.
- Sample n phase (full width) = n·FREQ_INIT + n(n-1)/2·FREQ_STEP mod 2^PHASE_W.
- SIGN_START_CALC high only for sample 0. SIGN_STOP_CALC high only for sample PULSE_LEN-1. With PULSE_LEN = 1, both are high in the same cycle.
- After the last sample, the block returns to IDLE, reloads acc and freq, and drops VALID and BUSY.
- START during RUN is ignored; no retrigger or extension.
- Reset value of every output is 0. Reset assertion mid-pulse aborts immediately (asynchronously), with no stop marker.

## Timing
- START accepted at edge k: VALID, BUSY, and SIGN_START_CALC go high after edge k, with PHASE = sample 0.
- Sample n is presented after edge k+n. SIGN_STOP_CALC is presented after edge k+PULSE_LEN-1.
- VALID and BUSY fall after edge k+PULSE_LEN.
- Earliest next acceptance is edge k+PULSE_LEN, provided START = 1 and READY = 1 then. READY is normally low at that point because the downstream drain delay has not yet elapsed.
- VALID is continuous within a pulse: exactly PULSE_LEN consecutive cycles, no gaps.

## Configuration
- LFM_DOWN_CHIRP_EN defined: the freq update becomes freq ← freq − FREQ_STEP (mod 2^PHASE_W), giving a descending chirp. Sample phase = n·FREQ_INIT − n(n-1)/2·FREQ_STEP.
- Not defined: ascending chirp as described above. All timing is identical in both builds.

## Test plan
Unless stated, all scenarios use PHASE_W = 16, OUT_W = 12, FREQ_INIT = 16'h0100, FREQ_STEP = 16'h0010, PULSE_LEN = 4.
- Basic up-chirp: READY = 1, START pulse for 1 cycle -> PHASE = 0x000, 0x010, 0x021, 0x033 on 4 consecutive VALID cycles. SIGN_START_CALC is set on the first cycle and SIGN_STOP_CALC on the fourth; BUSY is low on the fifth.
- LFM_DOWN_CHIRP_EN build, same stimulus -> PHASE = 0x000, 0x010, 0x01F, 0x02D.
- Wrap-around: FREQ_INIT = 16'hF000, FREQ_STEP = 0, PULSE_LEN = 3 -> PHASE = 0x000, 0xF00, 0xE00; no stall or flag from the overflow.
- Handshake: hold START = 1 with READY = 0 for 5 cycles -> VALID stays 0. Raise READY -> sample 0 appears one cycle later. START pulses during RUN change nothing.
- PULSE_LEN = 1 -> one VALID cycle with PHASE = 0x000 and both SIGN_START_CALC and SIGN_STOP_CALC high together.
- Reset mid-pulse: assert RESET low between edges during sample 2 -> all outputs are 0 immediately, with no SIGN_STOP_CALC. Release reset and START again -> the sequence restarts at 0x000.
